serial_accumulator_n: RTL and testbench
=======================================

# serial_accumulator_n

Parametrised serial accumulator for the board-level accumulator design. Adds a `data_in` word into a running sum once per debounced `load_btn` press. Supports configurable data width, sum width and sample limit, plus wrap, saturating-add and saturating-subtract modes. Sits between the board buttons/switches and the LED/display outputs in place of the fixed 8-bit accumulator, and runs completion on either a stop press or a sample-count limit.

## Interface
- `DATA_W`, default 8: width of `data_in`.
- `SUM_W`, default 8: width of the sum; must be ≥ `DATA_W`.
- `MAX_COUNT`, default 16: number of accumulations after which the block enters DONE; must be ≥ 1.
- `DB_CYCLES`, default 1_000_000: debounce stability count, in clocks; simulation benches use 2.
- `CNT_W`, default `$clog2(MAX_COUNT+1)`: width of `count_out`.

Ports:
- `clk`  in  1  system clock; all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `data_in`  in  DATA_W  operand; zero-extended to SUM_W.
- `mode`  in  2  00 wrap add, 01 saturating add, 10 saturating subtract, 11 treated as 00.
- `load_btn`  in  1  raw accumulate/restart button; asynchronous and may bounce.
- `stop_btn`  in  1  raw stop button; asynchronous and may bounce.
- `sum_out`  out  SUM_W  running sum.
- `count_out`  out  CNT_W  accumulations performed since the last clear.
- `ready_led`  out  1  high in READY.
- `done_led`  out  1  high in DONE.
- `overflow_led`  out  1  sticky; high once any wrap or clamp has occurred.

## Operation
- Each button path has three stages:
  - Two-flop synchroniser (`s1`, `s2`).
  - Debouncer holding `db_level` and a counter. The counter increments on every edge where `s2 != db_level` and resets to 0 on any edge where they are equal. `db_level` toggles when `s2` has differed on `DB_CYCLES` consecutive edges.
  - Registered rising-edge detector, which produces a 1-cycle internal pulse (`load_p`, `stop_p`).
- The state machine has two states, READY and DONE.
- READY, `load_p`:
  - `sum` ← op(`sum`, `data_in`, `mode`), using `data_in` and `mode` as sampled in the pulse cycle.
  - `count` increments.
  - If the new `count` equals `MAX_COUNT`, go to DONE.
- READY, `stop_p`: go to DONE; `sum` and `count` are held.
- READY, `load_p` and `stop_p` in the same cycle: the accumulate is performed, then the state goes to DONE.
- DONE, `stop_p`: ignored.
- DONE, `load_p`: clear `sum`, `count` and `overflow`, then go to READY. This press is not accumulated.
- Arithmetic is done at SUM_W+1 bits:
  - Mode 00: result truncated to SUM_W; `overflow` is set if the carry bit is 1.
  - Mode 01: if the carry bit is 1, the result clamps to 2^SUM_W−1 and `overflow` is set.
  - Mode 10: if `data_in` > `sum`, the result clamps to 0 and `overflow` is set; otherwise it is `sum − data_in`.
- `overflow` is sticky. Only reset or a DONE→READY clear clears it.
- `count` never exceeds `MAX_COUNT`.
- Outputs are registered state. `ready_led` equals (state==READY) and `done_led` equals (state==DONE); both are decoded from the state register with no glitch-prone logic.

## Timing
- Reset is asynchronous. While `reset` is high:
  - `sum_out` = 0, `count_out` = 0, `overflow_led` = 0.
  - State = READY, so `ready_led` = 1 and `done_led` = 0.
  - All synchroniser, debouncer and edge-detector flops = 0.
- Reset asserted mid-debounce or mid-operation aborts immediately, with no pending pulse surviving.
- Press latency: if the raw button is first sampled high at edge k:
  - `s2` goes high at edge k+1.
  - `db_level` rises at edge k+1+DB_CYCLES.
  - `sum_out`, `count_out` and state update at edge k+2+DB_CYCLES.
  - With DB_CYCLES=2, that is edge k+4.
- A press shorter than DB_CYCLES+1 clocks, or a bounce that returns low before the counter completes, produces no pulse.
- Release is debounced identically. A new press is recognised only after `db_level` has returned to 0.
- One press produces exactly one pulse, regardless of hold length.
- `data_in` and `mode` must be stable during the pulse cycle (edge k+1+DB_CYCLES through edge k+2+DB_CYCLES).

## Test plan
All scenarios use DATA_W=8, SUM_W=8, MAX_COUNT=4, DB_CYCLES=2.

- Reset, then mode 00 presses of 10, 20, 30, each held 6 cycles → `sum_out`=60, `count_out`=3, `ready_led`=1, `overflow_led`=0. Each update lands exactly at edge k+4.
- Mode 00 presses of 200 then 100 → `sum_out`=44, `overflow_led`=1. Mode 01 from reset with the same data → `sum_out`=255, `overflow_led`=1.
- Mode 00 press of 5, then mode 10 press of 9 → `sum_out`=0, `overflow_led`=1. Mode 10 press of 5 from `sum_out`=7 → 2.
- Four presses of 1 → after the 4th, `done_led`=1, `ready_led`=0, `count_out`=4. A 5th press leaves `sum_out`=4. The next press clears to 0/0, `ready_led`=1, `overflow_led`=0.
- Stop press after 2 loads → DONE with `sum_out` and `count_out` held. A stop press while in DONE changes nothing. Load and stop rising together in READY → that sum is included and DONE is entered.
- `load_btn` toggled every cycle for 12 cycles, then low → no change to `sum_out`. `reset` pulsed high 3 cycles into a valid press → all outputs at reset values asynchronously, and no accumulate after release.

Source files
------------

// File: rtl/serial_accumulator_n.sv
// rtl/serial_accumulator_n.sv - debounced-button serial accumulator with wrap/saturate modes
// Each load press folds data_in into the sum; completion on stop press or sample limit.
module serial_accumulator_n #(
  parameter int DATA_W    = 8,
  parameter int SUM_W     = 8,
  parameter int MAX_COUNT = 16,
  parameter int DB_CYCLES = 1_000_000,
  parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        mode,
  input  logic              load_btn,
  input  logic              stop_btn,
  output logic [SUM_W-1:0]  sum_out,
  output logic [CNT_W-1:0]  count_out,
  output logic              ready_led,
  output logic              done_led,
  output logic              overflow_led
);

  localparam int DB_CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
  localparam logic [DB_CW-1:0] DB_LAST = DB_CW'(DB_CYCLES - 1);
  localparam int BTN_LOAD = 0;
  localparam int BTN_STOP = 1;

  typedef enum logic {
    S_READY = 1'b0,
    S_DONE  = 1'b1
  } state_t;

  logic [1:0]       w_btn_raw;
  logic [1:0]       r_s1;
  logic [1:0]       r_s2;
  logic [1:0]       r_db_level;
  logic [1:0]       r_db_prev;
  logic [DB_CW-1:0] r_db_cnt [2];
  logic [1:0]       w_pulse;
  logic             w_load_p;
  logic             w_stop_p;

  assign w_btn_raw = {stop_btn, load_btn};

  // Both button paths share one process: sync, debounce, then edge-detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_db_level <= '0;
      r_db_prev  <= '0;
      r_db_cnt[0] <= '0;
      r_db_cnt[1] <= '0;
    end else begin
      r_s1      <= w_btn_raw;
      r_s2      <= r_s1;
      r_db_prev <= r_db_level;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] != r_db_level[i]) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_db_level[i] <= ~r_db_level[i];
            r_db_cnt[i]   <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + DB_CW'(1);
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_pulse  = r_db_level & ~r_db_prev;
  assign w_load_p = w_pulse[BTN_LOAD];
  assign w_stop_p = w_pulse[BTN_STOP];

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SUM_W-1:0] r_sum;
  logic [SUM_W-1:0] w_sum_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] w_count_inc;
  logic             r_ovf;
  logic             w_ovf_nxt;

  logic [SUM_W-1:0] w_data_ext;
  logic [SUM_W:0]   w_add;
  logic [SUM_W:0]   w_sub;
  logic [SUM_W-1:0] w_op_sum;
  logic             w_op_ovf;

  assign w_data_ext  = SUM_W'(data_in);
  assign w_add       = {1'b0, r_sum} + {1'b0, w_data_ext};
  assign w_sub       = {1'b0, r_sum} - {1'b0, w_data_ext};
  assign w_count_inc = r_count + CNT_W'(1);

  // Bit SUM_W of the widened result is the carry (add) or borrow (subtract).
  always_comb begin
    w_op_sum = w_add[SUM_W-1:0];
    w_op_ovf = w_add[SUM_W];
    case (mode)
      2'b01: begin
        if (w_add[SUM_W]) begin
          w_op_sum = '1;
          w_op_ovf = 1'b1;
        end
      end
      2'b10: begin
        w_op_sum = w_sub[SUM_W-1:0];
        w_op_ovf = w_sub[SUM_W];
        if (w_sub[SUM_W]) begin
          w_op_sum = '0;
        end
      end
      default: begin
        w_op_sum = w_add[SUM_W-1:0];
        w_op_ovf = w_add[SUM_W];
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sum_nxt   = r_sum;
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      S_READY: begin
        if (w_load_p) begin
          w_sum_nxt   = w_op_sum;
          w_count_nxt = w_count_inc;
          w_ovf_nxt   = r_ovf | w_op_ovf;
          if (w_stop_p || (w_count_inc == CNT_W'(MAX_COUNT))) begin
            w_state_nxt = S_DONE;
          end
        end else if (w_stop_p) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // The restart press only clears; it is not accumulated.
        if (w_load_p) begin
          w_sum_nxt   = '0;
          w_count_nxt = '0;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = S_READY;
        end
      end
      default: begin
        w_state_nxt = S_READY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_READY;
      r_sum   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sum   <= w_sum_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign sum_out      = r_sum;
  assign count_out    = r_count;
  assign overflow_led = r_ovf;
  assign ready_led    = (r_state == S_READY);
  assign done_led     = (r_state == S_DONE);

endmodule

// File: tb/tb_serial_accumulator_n.sv
// tb/tb_serial_accumulator_n.sv - directed self-checking bench for serial_accumulator_n
module tb_serial_accumulator_n;

  localparam int DATA_W    = 8;
  localparam int SUM_W     = 8;
  localparam int MAX_COUNT = 4;
  localparam int DB_CYCLES = 2;
  localparam int CNT_W     = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] data_in = '0;
  logic [1:0]        mode = 2'b00;
  logic              load_btn = 1'b0;
  logic              stop_btn = 1'b0;
  logic [SUM_W-1:0]  sum_out;
  logic [CNT_W-1:0]  count_out;
  logic              ready_led;
  logic              done_led;
  logic              overflow_led;

  int n_pass  = 0;
  int n_total = 0;

  serial_accumulator_n #(
    .DATA_W(DATA_W), .SUM_W(SUM_W), .MAX_COUNT(MAX_COUNT),
    .DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .mode(mode),
    .load_btn(load_btn), .stop_btn(stop_btn), .sum_out(sum_out),
    .count_out(count_out), .ready_led(ready_led), .done_led(done_led),
    .overflow_led(overflow_led)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1);
  end

  task automatic apply_reset;
    @(negedge clk);
    reset = 1'b1; load_btn = 1'b0; stop_btn = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic press(input logic ld, input logic st, input logic [7:0] d, input logic [1:0] m);
    @(negedge clk);
    data_in = d; mode = m; load_btn = ld; stop_btn = st;
    repeat (6) @(negedge clk);
    load_btn = 1'b0; stop_btn = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_total++; if (sum_out !== 8'd0) $display("FAIL rst_sum actual=%0d required=0", sum_out); else n_pass++;
    n_total++; if (count_out !== 3'd0) $display("FAIL rst_count actual=%0d required=0", count_out); else n_pass++;
    n_total++; if (ready_led !== 1'b1 || done_led !== 1'b0) $display("FAIL rst_leds actual=%b%b required=10", ready_led, done_led); else n_pass++;
    n_total++; if (overflow_led !== 1'b0) $display("FAIL rst_ovf actual=%b required=0", overflow_led); else n_pass++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wrap_latency;
    logic [7:0] vals [3];
    logic [7:0] exp_sum;
    vals[0] = 8'd10; vals[1] = 8'd20; vals[2] = 8'd30;
    exp_sum = 8'd0;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data_in = vals[i]; mode = 2'b00; load_btn = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      n_total++; if (sum_out !== exp_sum) $display("FAIL lat_early_%0d actual=%0d required=%0d", i, sum_out, exp_sum); else n_pass++;
      @(posedge clk);
      #1;
      exp_sum = exp_sum + vals[i];
      n_total++; if (sum_out !== exp_sum) $display("FAIL lat_k4_sum_%0d actual=%0d required=%0d", i, sum_out, exp_sum); else n_pass++;
      n_total++; if (count_out !== 3'(i + 1)) $display("FAIL lat_k4_count_%0d actual=%0d required=%0d", i, count_out, i + 1); else n_pass++;
      @(posedge clk);
      @(negedge clk);
      load_btn = 1'b0;
      repeat (6) @(negedge clk);
    end
    n_total++; if (sum_out !== 8'd60) $display("FAIL wrap60_sum actual=%0d required=60", sum_out); else n_pass++;
    n_total++; if (ready_led !== 1'b1 || overflow_led !== 1'b0) $display("FAIL wrap60_flags actual=%b%b required=10", ready_led, overflow_led); else n_pass++;
  endtask

  task automatic test_overflow;
    apply_reset();
    press(1, 0, 8'd200, 2'b00);
    press(1, 0, 8'd100, 2'b00);
    n_total++; if (sum_out !== 8'd44) $display("FAIL wrap_ovf_sum actual=%0d required=44", sum_out); else n_pass++;
    n_total++; if (overflow_led !== 1'b1) $display("FAIL wrap_ovf_led actual=%b required=1", overflow_led); else n_pass++;
    press(0, 1, 8'd0, 2'b00);
    press(1, 0, 8'd77, 2'b00);
    n_total++; if (overflow_led !== 1'b0 || sum_out !== 8'd0 || ready_led !== 1'b1) $display("FAIL ovf_clear actual=ovf%b sum%0d rdy%b required=ovf0 sum0 rdy1", overflow_led, sum_out, ready_led); else n_pass++;
    apply_reset();
    press(1, 0, 8'd200, 2'b01);
    press(1, 0, 8'd100, 2'b01);
    n_total++; if (sum_out !== 8'd255) $display("FAIL sat_add_sum actual=%0d required=255", sum_out); else n_pass++;
    n_total++; if (overflow_led !== 1'b1) $display("FAIL sat_add_ovf actual=%b required=1", overflow_led); else n_pass++;
  endtask

  task automatic test_subtract;
    apply_reset();
    press(1, 0, 8'd5, 2'b00);
    press(1, 0, 8'd9, 2'b10);
    n_total++; if (sum_out !== 8'd0) $display("FAIL sat_sub_clamp actual=%0d required=0", sum_out); else n_pass++;
    n_total++; if (overflow_led !== 1'b1) $display("FAIL sat_sub_ovf actual=%b required=1", overflow_led); else n_pass++;
    apply_reset();
    press(1, 0, 8'd7, 2'b00);
    press(1, 0, 8'd5, 2'b10);
    n_total++; if (sum_out !== 8'd2) $display("FAIL sub_plain actual=%0d required=2", sum_out); else n_pass++;
    n_total++; if (overflow_led !== 1'b0) $display("FAIL sub_plain_ovf actual=%b required=0", overflow_led); else n_pass++;
  endtask

  task automatic test_count_limit;
    apply_reset();
    for (int i = 0; i < 4; i++) press(1, 0, 8'd1, 2'b00);
    n_total++; if (done_led !== 1'b1 || ready_led !== 1'b0) $display("FAIL limit_leds actual=%b%b required=01", ready_led, done_led); else n_pass++;
    n_total++; if (count_out !== 3'd4 || sum_out !== 8'd4) $display("FAIL limit_vals actual=%0d/%0d required=4/4", sum_out, count_out); else n_pass++;
    press(0, 1, 8'd1, 2'b00);
    n_total++; if (sum_out !== 8'd4 || count_out !== 3'd4 || done_led !== 1'b1) $display("FAIL limit_hold actual=%0d/%0d done%b required=4/4 done1", sum_out, count_out, done_led); else n_pass++;
    press(1, 0, 8'd1, 2'b00);
    n_total++; if (sum_out !== 8'd0 || count_out !== 3'd0) $display("FAIL restart_clear actual=%0d/%0d required=0/0", sum_out, count_out); else n_pass++;
    n_total++; if (ready_led !== 1'b1 || overflow_led !== 1'b0) $display("FAIL restart_flags actual=%b%b required=10", ready_led, overflow_led); else n_pass++;
  endtask

  task automatic test_stop;
    apply_reset();
    press(1, 0, 8'd3, 2'b00);
    press(1, 0, 8'd4, 2'b00);
    press(0, 1, 8'd50, 2'b00);
    n_total++; if (done_led !== 1'b1 || sum_out !== 8'd7 || count_out !== 3'd2) $display("FAIL stop_enter actual=done%b %0d/%0d required=done1 7/2", done_led, sum_out, count_out); else n_pass++;
    press(0, 1, 8'd50, 2'b00);
    n_total++; if (done_led !== 1'b1 || sum_out !== 8'd7 || count_out !== 3'd2) $display("FAIL stop_in_done actual=done%b %0d/%0d required=done1 7/2", done_led, sum_out, count_out); else n_pass++;
    press(1, 0, 8'd50, 2'b00);
    press(1, 0, 8'd5, 2'b00);
    press(1, 1, 8'd6, 2'b00);
    n_total++; if (sum_out !== 8'd11 || count_out !== 3'd2) $display("FAIL load_stop_sum actual=%0d/%0d required=11/2", sum_out, count_out); else n_pass++;
    n_total++; if (done_led !== 1'b1) $display("FAIL load_stop_done actual=%b required=1", done_led); else n_pass++;
  endtask

  task automatic test_bounce_and_reset;
    apply_reset();
    press(1, 0, 8'd3, 2'b00);
    @(negedge clk);
    data_in = 8'd8;
    for (int i = 0; i < 12; i++) begin
      load_btn = ~load_btn;
      @(negedge clk);
    end
    load_btn = 1'b0;
    repeat (10) @(negedge clk);
    n_total++; if (sum_out !== 8'd3 || count_out !== 3'd1) $display("FAIL bounce_ignored actual=%0d/%0d required=3/1", sum_out, count_out); else n_pass++;
    @(negedge clk);
    data_in = 8'd9; load_btn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_total++; if (sum_out !== 8'd0 || count_out !== 3'd0) $display("FAIL async_rst_vals actual=%0d/%0d required=0/0", sum_out, count_out); else n_pass++;
    n_total++; if (ready_led !== 1'b1 || done_led !== 1'b0 || overflow_led !== 1'b0) $display("FAIL async_rst_leds actual=%b%b%b required=100", ready_led, done_led, overflow_led); else n_pass++;
    load_btn = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    n_total++; if (sum_out !== 8'd0 || count_out !== 3'd0) $display("FAIL rst_no_pulse actual=%0d/%0d required=0/0", sum_out, count_out); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_wrap_latency();
    test_overflow();
    test_subtract();
    test_count_limit();
    test_stop();
    test_bounce_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
